// File: rtl/serial_display_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_display_driver_if
// Description : Load/busy/done handshake and BCD value bus between the
//               bin-to-BCD conversion logic (master) and the serial display
//               driver (slave).
//   VALUE_BCD  : 4*WORDS-bit BCD value, digit i at bits [4i+3:4i]
//   load       : frame start request (master -> driver)
//   busy       : frame or gap in progress (driver -> master)
//   frame_done : one-cycle pulse at the end of the gap (driver -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_display_driver_if #(
  parameter int WORDS = 4
);
  logic [4*WORDS-1:0] VALUE_BCD;
  logic               load;
  logic               busy;
  logic               frame_done;

  modport master (
    output VALUE_BCD,
    output load,
    input  busy,
    input  frame_done
  );

  modport slave (
    input  VALUE_BCD,
    input  load,
    output busy,
    output frame_done
  );
endinterface
`default_nettype wire

// File: rtl/serial_display_driver.sv
`default_nettype none
// ============================================================================
// Module      : serial_display_driver
// Description : Serial driver for the BCD seven-segment display board.
//               Generates the free-running board clock and serial data clock,
//               and shifts a 4*WORDS-bit BCD frame out on VALUE_SIGNAL framed
//               by ENABLE_SIGNAL, followed by GAP_BITS blank data-clock
//               periods.
//   internal_clock     : system clock, rising edge
//   RST                : asynchronous active-low reset
//   bus                : slave side of the VALUE_BCD/load/busy/frame_done bus
//   VALUE_SIGNAL       : serial data, updated on data clock rising edge
//   ENABLE_SIGNAL      : high while frame bits are valid
//   BOARD_CLOCK_SIGNAL : board clock, half period BOARD_DIV cycles
//   DATA_CLOCK_SIGNAL  : serial clock, half period DATA_DIV cycles
// Revision    : 1.0 - initial release
// ============================================================================
module serial_display_driver #(
  parameter int WORDS      = 4,
  parameter int BOARD_DIV  = 400,
  parameter int DATA_DIV   = 2000,
  parameter int GAP_BITS   = 16,
  parameter bit LSD_FIRST  = 1'b1,
  parameter bit CONTINUOUS = 1'b1
) (
  input  wire logic              internal_clock,
  input  wire logic              RST,
  serial_display_driver_if.slave bus,
  output logic                   VALUE_SIGNAL,
  output logic                   ENABLE_SIGNAL,
  output logic                   BOARD_CLOCK_SIGNAL,
  output logic                   DATA_CLOCK_SIGNAL
);

  localparam int BW = (BOARD_DIV > 1) ? $clog2(BOARD_DIV) : 1;
  localparam int DW = (DATA_DIV  > 1) ? $clog2(DATA_DIV)  : 1;
  localparam int GW = (GAP_BITS  > 1) ? $clog2(GAP_BITS)  : 1;
  localparam int IW = $clog2(4*WORDS);

  localparam logic [BW-1:0] BOARD_LAST = BW'(BOARD_DIV - 1);
  localparam logic [DW-1:0] DATA_LAST  = DW'(DATA_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_BITS - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(4*WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  logic [BW-1:0]      board_cnt_q;
  logic               board_clk_q;
  logic [DW-1:0]      data_cnt_q;
  logic               data_clk_q;

  state_t             state_q;
  logic [4*WORDS-1:0] snap_q;
  logic [IW-1:0]      idx_q;
  logic [GW-1:0]      gap_cnt_q;
  logic               busy_q;
  logic               done_q;
  logic               value_q;
  logic               enable_q;

  logic               data_tick;
  logic [31:0]        digit_d;
  logic [31:0]        bit_pos_d;
  logic [4*WORDS-1:0] snap_shift_d;
  logic               bit_d;

  // Board clock divider, free-running in every state.
  always_ff @(posedge internal_clock or negedge RST) begin
    if (!RST) begin
      board_cnt_q <= '0;
      board_clk_q <= 1'b0;
    end else if (board_cnt_q == BOARD_LAST) begin
      board_cnt_q <= '0;
      board_clk_q <= ~board_clk_q;
    end else begin
      board_cnt_q <= board_cnt_q + BW'(1);
    end
  end

  // Data clock divider, free-running in every state.
  always_ff @(posedge internal_clock or negedge RST) begin
    if (!RST) begin
      data_cnt_q <= '0;
      data_clk_q <= 1'b0;
    end else if (data_cnt_q == DATA_LAST) begin
      data_cnt_q <= '0;
      data_clk_q <= ~data_clk_q;
    end else begin
      data_cnt_q <= data_cnt_q + DW'(1);
    end
  end

  // Marks the cycle whose closing edge raises the data clock; outputs change
  // there so the board can sample them on the following falling edge.
  assign data_tick = ~data_clk_q & (data_cnt_q == DATA_LAST);

  // Serial bit selection: digit n/4 (reversed for MSD-first), nibble MSB
  // first. A right shift avoids a wide variable index into the snapshot.
  always_comb begin
    digit_d = 32'(idx_q) >> 2;
    if (!LSD_FIRST) begin
      digit_d = 32'(WORDS - 1) - digit_d;
    end
    bit_pos_d    = (digit_d << 2) + 32'd3 - 32'(idx_q[1:0]);
    snap_shift_d = snap_q >> bit_pos_d;
  end

  assign bit_d = snap_shift_d[0];

  always_ff @(posedge internal_clock or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      snap_q    <= '0;
      idx_q     <= '0;
      gap_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      value_q   <= 1'b0;
      enable_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // A load coinciding with frame_done is dropped; continuous mode
          // starts on its own straight after reset.
          if ((bus.load || CONTINUOUS) && !done_q) begin
            state_q <= S_SHIFT;
            snap_q  <= bus.VALUE_BCD;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (data_tick) begin
            enable_q <= 1'b1;
            value_q  <= bit_d;
            if (idx_q == LAST_IDX) begin
              state_q   <= S_GAP;
              gap_cnt_q <= '0;
            end else begin
              idx_q <= idx_q + IW'(1);
            end
          end
        end
        S_GAP: begin
          if (data_tick) begin
            enable_q <= 1'b0;
            value_q  <= 1'b0;
            if (gap_cnt_q == GAP_LAST) begin
              done_q <= 1'b1;
              if (CONTINUOUS) begin
                state_q <= S_SHIFT;
                snap_q  <= bus.VALUE_BCD;
                idx_q   <= '0;
              end else begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              gap_cnt_q <= gap_cnt_q + GW'(1);
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy           = busy_q;
  assign bus.frame_done     = done_q;
  assign VALUE_SIGNAL       = value_q;
  assign ENABLE_SIGNAL      = enable_q;
  assign BOARD_CLOCK_SIGNAL = board_clk_q;
  assign DATA_CLOCK_SIGNAL  = data_clk_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_display_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_display_driver
// Description : Self-checking bench for serial_display_driver. Four instances
//               cover LSD-first one-shot, MSD-first one-shot, divider timing
//               and continuous mode. Expected serial bits are queued when the
//               value is applied and popped on every observed data-clock rise.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_display_driver;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_display_driver_if #(.WORDS(2)) if_basic ();
  serial_display_driver_if #(.WORDS(2)) if_msd   ();
  serial_display_driver_if #(.WORDS(2)) if_div   ();
  serial_display_driver_if #(.WORDS(2)) if_cont  ();

  logic b_val, b_en, b_bclk, b_dclk;
  logic m_val, m_en, m_bclk, m_dclk;
  logic d_val, d_en, d_bclk, d_dclk;
  logic c_val, c_en, c_bclk, c_dclk;

  serial_display_driver #(.WORDS(2), .BOARD_DIV(1), .DATA_DIV(2), .GAP_BITS(2),
                          .LSD_FIRST(1'b1), .CONTINUOUS(1'b0)) u_basic (
    .internal_clock(clk), .RST(rst_n), .bus(if_basic.slave),
    .VALUE_SIGNAL(b_val), .ENABLE_SIGNAL(b_en),
    .BOARD_CLOCK_SIGNAL(b_bclk), .DATA_CLOCK_SIGNAL(b_dclk));

  serial_display_driver #(.WORDS(2), .BOARD_DIV(1), .DATA_DIV(2), .GAP_BITS(2),
                          .LSD_FIRST(1'b0), .CONTINUOUS(1'b0)) u_msd (
    .internal_clock(clk), .RST(rst_n), .bus(if_msd.slave),
    .VALUE_SIGNAL(m_val), .ENABLE_SIGNAL(m_en),
    .BOARD_CLOCK_SIGNAL(m_bclk), .DATA_CLOCK_SIGNAL(m_dclk));

  serial_display_driver #(.WORDS(2), .BOARD_DIV(3), .DATA_DIV(5), .GAP_BITS(2),
                          .LSD_FIRST(1'b1), .CONTINUOUS(1'b0)) u_div (
    .internal_clock(clk), .RST(rst_n), .bus(if_div.slave),
    .VALUE_SIGNAL(d_val), .ENABLE_SIGNAL(d_en),
    .BOARD_CLOCK_SIGNAL(d_bclk), .DATA_CLOCK_SIGNAL(d_dclk));

  serial_display_driver #(.WORDS(2), .BOARD_DIV(1), .DATA_DIV(2), .GAP_BITS(2),
                          .LSD_FIRST(1'b1), .CONTINUOUS(1'b1)) u_cont (
    .internal_clock(clk), .RST(rst_n), .bus(if_cont.slave),
    .VALUE_SIGNAL(c_val), .ENABLE_SIGNAL(c_en),
    .BOARD_CLOCK_SIGNAL(c_bclk), .DATA_CLOCK_SIGNAL(c_dclk));

  // Reference bit n of an LSD-first 2-digit frame: digit n/4, MSB first.
  function automatic logic model_bit(input logic [7:0] v, input int n);
    logic [7:0] t;
    t = v >> (4*(n/4) + 3 - (n%4));
    return t[0];
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    if_basic.load = 1'b0;
    if_msd.load   = 1'b0;
    if_div.load   = 1'b0;
    if_cont.load  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [5:0] got;
    rst_n = 1'b0;
    if_basic.load = 1'b0; if_msd.load = 1'b0; if_div.load = 1'b0; if_cont.load = 1'b0;
    if_basic.VALUE_BCD = 8'h00; if_msd.VALUE_BCD = 8'h00;
    if_div.VALUE_BCD = 8'h00; if_cont.VALUE_BCD = 8'h12;
    repeat (2) @(negedge clk);
    got = {b_val, b_en, b_bclk, b_dclk, if_basic.busy, if_basic.frame_done};
    vectors++;
    if (got !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_basic_outputs: got %b expected 000000", got);
    end
    got = {c_val, c_en, c_bclk, c_dclk, if_cont.busy, if_cont.frame_done};
    vectors++;
    if (got !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_cont_outputs: got %b expected 000000", got);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (if_basic.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset_busy: got %b expected 0", if_basic.busy);
    end
    vectors++;
    if (if_cont.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL cont_autostart_busy: got %b expected 1", if_cont.busy);
    end
  endtask

  task automatic test_dividers();
    logic exp_b, exp_d;
    apply_reset();
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      exp_b = ((k / 3) % 2) != 0;
      exp_d = ((k / 5) % 2) != 0;
      vectors++;
      if (d_bclk !== exp_b) begin
        miscompares++;
        $display("FAIL board_clock cycle %0d: got %b expected %b", k, d_bclk, exp_b);
      end
      vectors++;
      if (d_dclk !== exp_d) begin
        miscompares++;
        $display("FAIL data_clock cycle %0d: got %b expected %b", k, d_dclk, exp_d);
      end
      vectors++;
      if (if_div.busy !== 1'b0) begin
        miscompares++;
        $display("FAIL div_busy cycle %0d: got %b expected 0", k, if_div.busy);
      end
    end
  endtask

  task automatic test_basic();
    logic       exp_q[$];
    logic [7:0] seq = 8'b1001_0101;
    logic       e;
    logic       prev;
    int         ticks = 0;
    int         dones = 0;
    int         cyc   = 0;
    apply_reset();
    if_basic.VALUE_BCD = 8'h59;
    for (int i = 0; i < 8; i++) exp_q.push_back(seq[7-i]);
    if_basic.load = 1'b1;
    @(negedge clk);
    if_basic.load = 1'b0;
    vectors++;
    if (if_basic.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_busy_after_load: got %b expected 1", if_basic.busy);
    end
    prev = b_dclk;
    while (ticks < 10 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (!prev && b_dclk) begin
        ticks++;
        if (ticks <= 8) begin
          e = exp_q.pop_front();
          vectors++;
          if (b_en !== 1'b1 || b_val !== e) begin
            miscompares++;
            $display("FAIL basic_bit %0d: got en=%b val=%b expected en=1 val=%b", ticks, b_en, b_val, e);
          end
        end else begin
          vectors++;
          if (b_en !== 1'b0 || b_val !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_gap %0d: got en=%b val=%b expected 0 0", ticks, b_en, b_val);
          end
        end
      end
      if (ticks == 10) begin
        vectors++;
        if (if_basic.frame_done !== 1'b1 || if_basic.busy !== 1'b0) begin
          miscompares++;
          $display("FAIL basic_done: got done=%b busy=%b expected 1 0", if_basic.frame_done, if_basic.busy);
        end
      end else if (if_basic.frame_done === 1'b1) begin
        dones++;
      end
      prev = b_dclk;
    end
    vectors++;
    if (ticks != 10) begin
      miscompares++;
      $display("FAIL basic_timeout: got %0d ticks expected 10", ticks);
    end
    repeat (16) begin
      @(negedge clk);
      if (if_basic.frame_done === 1'b1 || if_basic.busy === 1'b1 || b_en === 1'b1) dones++;
    end
    vectors++;
    if (dones != 0) begin
      miscompares++;
      $display("FAIL basic_extra_activity: got %0d events expected 0", dones);
    end
  endtask

  task automatic test_digit_order();
    logic       exp_q[$];
    logic [7:0] seq = 8'b0101_1001;
    logic       e;
    logic       prev;
    int         ticks = 0;
    int         cyc   = 0;
    apply_reset();
    if_msd.VALUE_BCD = 8'h59;
    for (int i = 0; i < 8; i++) exp_q.push_back(seq[7-i]);
    if_msd.load = 1'b1;
    @(negedge clk);
    if_msd.load = 1'b0;
    prev = m_dclk;
    while (ticks < 10 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (!prev && m_dclk) begin
        ticks++;
        if (ticks <= 8) begin
          e = exp_q.pop_front();
          vectors++;
          if (m_en !== 1'b1 || m_val !== e) begin
            miscompares++;
            $display("FAIL msd_bit %0d: got en=%b val=%b expected en=1 val=%b", ticks, m_en, m_val, e);
          end
        end else begin
          vectors++;
          if (m_en !== 1'b0) begin
            miscompares++;
            $display("FAIL msd_gap %0d: got en=%b expected 0", ticks, m_en);
          end
        end
      end
      prev = m_dclk;
    end
    vectors++;
    if (ticks != 10 || if_msd.frame_done !== 1'b1) begin
      miscompares++;
      $display("FAIL msd_done: got ticks=%0d done=%b expected 10 1", ticks, if_msd.frame_done);
    end
  endtask

  task automatic test_ignored_load();
    logic exp_q[$];
    logic e;
    logic prev;
    int   ticks    = 0;
    int   dones    = 0;
    int   release_ = 0;
    apply_reset();
    if_basic.VALUE_BCD = 8'h59;
    for (int i = 0; i < 8; i++) exp_q.push_back(model_bit(8'h59, i));
    if_basic.load = 1'b1;
    @(negedge clk);
    if_basic.load = 1'b0;
    prev = b_dclk;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (release_ != 0) begin
        if_basic.load = 1'b0;
        release_ = 0;
      end
      if (!prev && b_dclk) begin
        ticks++;
        if (ticks == 3) begin
          if_basic.load = 1'b1;
          release_ = 1;
        end
        if (b_en === 1'b1) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL ignload_extra_bit at tick %0d: got an enabled bit expected none", ticks);
          end else begin
            e = exp_q.pop_front();
            if (b_val !== e) begin
              miscompares++;
              $display("FAIL ignload_bit %0d: got %b expected %b", ticks, b_val, e);
            end
          end
        end
      end
      if (if_basic.frame_done === 1'b1) begin
        dones++;
        if_basic.load = 1'b1;
        release_ = 1;
      end
      prev = b_dclk;
    end
    vectors++;
    if (dones != 1 || exp_q.size() != 0 || if_basic.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL ignload_summary: got dones=%0d left=%0d busy=%b expected 1 0 0", dones, exp_q.size(), if_basic.busy);
    end
    if_basic.load = 1'b1;
    @(negedge clk);
    if_basic.load = 1'b0;
    vectors++;
    if (if_basic.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL ignload_later_accept: got busy=%b expected 1", if_basic.busy);
    end
  endtask

  task automatic test_mid_reset();
    logic [5:0] got;
    logic       prev;
    int         ticks = 0;
    int         cyc   = 0;
    int         bad   = 0;
    apply_reset();
    if_basic.VALUE_BCD = 8'h59;
    if_basic.load = 1'b1;
    @(negedge clk);
    if_basic.load = 1'b0;
    prev = b_dclk;
    while (ticks < 4 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (!prev && b_dclk) ticks++;
      prev = b_dclk;
    end
    vectors++;
    if (ticks != 4 || b_en !== 1'b1 || b_val !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_bit3: got ticks=%0d en=%b val=%b expected 4 1 1", ticks, b_en, b_val);
    end
    rst_n = 1'b0;
    #1;
    got = {b_val, b_en, b_bclk, b_dclk, if_basic.busy, if_basic.frame_done};
    vectors++;
    if (got !== 6'b0) begin
      miscompares++;
      $display("FAIL midrst_outputs: got %b expected 000000", got);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (if_basic.busy !== 1'b0 || b_en !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL midrst_stays_idle: got %0d active cycles expected 0", bad);
    end
    if_basic.load = 1'b1;
    @(negedge clk);
    if_basic.load = 1'b0;
    vectors++;
    if (if_basic.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_reload: got busy=%b expected 1", if_basic.busy);
    end
  endtask

  task automatic test_continuous();
    logic exp_q[$];
    logic e;
    logic prev;
    int   ticks = 0;
    int   cyc   = 0;
    rst_n = 1'b0;
    if_cont.load = 1'b0;
    if_cont.VALUE_BCD = 8'h12;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) exp_q.push_back(model_bit(8'h12, i));
    rst_n = 1'b1;
    prev = c_dclk;
    while (ticks < 20 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (!prev && c_dclk) begin
        ticks++;
        if (ticks == 3) begin
          if_cont.VALUE_BCD = 8'h34;
          for (int i = 0; i < 8; i++) exp_q.push_back(model_bit(8'h34, i));
        end
        vectors++;
        if (if_cont.busy !== 1'b1) begin
          miscompares++;
          $display("FAIL cont_busy tick %0d: got %b expected 1", ticks, if_cont.busy);
        end
        if ((ticks - 1) % 10 < 8) begin
          e = exp_q.pop_front();
          vectors++;
          if (c_en !== 1'b1 || c_val !== e) begin
            miscompares++;
            $display("FAIL cont_bit tick %0d: got en=%b val=%b expected en=1 val=%b", ticks, c_en, c_val, e);
          end
        end else begin
          vectors++;
          if (c_en !== 1'b0 || c_val !== 1'b0) begin
            miscompares++;
            $display("FAIL cont_gap tick %0d: got en=%b val=%b expected 0 0", ticks, c_en, c_val);
          end
        end
        if (ticks % 10 == 0) begin
          vectors++;
          if (if_cont.frame_done !== 1'b1) begin
            miscompares++;
            $display("FAIL cont_done tick %0d: got %b expected 1", ticks, if_cont.frame_done);
          end
        end
      end
      prev = c_dclk;
    end
    vectors++;
    if (ticks != 20 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL cont_timeout: got ticks=%0d left=%0d expected 20 0", ticks, exp_q.size());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_dividers();
    test_basic();
    test_digit_order();
    test_ignored_load();
    test_mid_reset();
    test_continuous();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_display_driver.md
# serial_display_driver

Parametrised serial driver for the BCD seven-segment display board. It generates the free-running board clock and the serial data clock. It shifts a frame of `4*WORDS` BCD bits out on `VALUE_SIGNAL`, framed by `ENABLE_SIGNAL` and followed by a blank gap. It sits between the bin-to-BCD conversion logic and the display board pins, and adds configurable dividers, a digit order mode, a configurable gap, one-shot/continuous modes and a load/busy/done handshake.

## Interface
- `WORDS`, 4: number of BCD digits per frame (≥1).
- `BOARD_DIV`, 400: half period of `BOARD_CLOCK_SIGNAL`, in `internal_clock` cycles (≥1).
- `DATA_DIV`, 2000: half period of `DATA_CLOCK_SIGNAL`, in `internal_clock` cycles (≥1).
- `GAP_BITS`, 16: number of blank data-clock periods after each frame (≥1).
- `LSD_FIRST`, 1: 1 = digit 0 (`VALUE_BCD[3:0]`) is sent first; 0 = digit `WORDS-1` is sent first.
- `CONTINUOUS`, 1: 1 = frames repeat automatically; 0 = each frame needs a `load`.

- `internal_clock` in 1: single system clock; all logic is on its rising edge.
- `RST` in 1: asynchronous, active-low reset.
- `VALUE_BCD` in 4*WORDS: digit i is at bits [4i+3:4i].
- `load` in 1: frame start request; sampled only in IDLE.
- `busy` out 1: high while a frame or gap is in progress.
- `frame_done` out 1: one-cycle pulse at the end of the gap.
- `VALUE_SIGNAL` out 1: serial data.
- `ENABLE_SIGNAL` out 1: high while frame bits are valid.
- `BOARD_CLOCK_SIGNAL` out 1: divided board clock, 50% duty.
- `DATA_CLOCK_SIGNAL` out 1: divided serial clock, 50% duty.

## Operation
- **Dividers**
  - Each divider has a counter of width `$clog2(DIV)`, counting 0..DIV-1.
  - When the counter is at DIV-1 it wraps to 0 and its clock output toggles.
  - Both dividers free-run in every state.
- **tick**
  - Internal signal, high for one cycle when `DATA_CLOCK_SIGNAL` is 0 and its counter is at DIV-1.
  - It therefore marks the cycle where the data clock rises.
  - `VALUE_SIGNAL` and `ENABLE_SIGNAL` update only on tick, so the board samples them on the falling edge of the data clock.
- **States:** IDLE, SHIFT, GAP.
- **IDLE**
  - Enters SHIFT when `load`=1. With `CONTINUOUS`=1 it also enters SHIFT on the first cycle after reset without waiting for `load`.
  - On entry, `VALUE_BCD` is captured into a snapshot register and the bit index is cleared to 0.
- **SHIFT** (on each tick)
  - `ENABLE_SIGNAL`=1.
  - `VALUE_SIGNAL` = snapshot bit for index n, where digit d = n/4 (mapped to `WORDS-1-d` when `LSD_FIRST`=0), and the bit within the digit is 3-(n%4), so each nibble goes out MSB first.
  - n increments. After the tick that drives n=`4*WORDS-1`, the state moves to GAP with the gap counter at 0.
- **GAP** (on each tick)
  - `ENABLE_SIGNAL`=0 and `VALUE_SIGNAL`=0; the gap counter increments.
  - After `GAP_BITS` ticks, `frame_done` pulses for one cycle. The next state is SHIFT (with a new snapshot) when `CONTINUOUS`=1, otherwise IDLE.
- **busy** = (state != IDLE), registered.
- **Input handling**
  - `VALUE_BCD` changes during a frame do not affect that frame.
  - `load` outside IDLE is ignored. In `CONTINUOUS` mode, `load` in IDLE is also honoured.
- **Reset** (async, any time including mid-frame): all outputs, state, snapshot and counters are cleared immediately.

## Timing
- Reset values: `VALUE_SIGNAL`, `ENABLE_SIGNAL`, `BOARD_CLOCK_SIGNAL`, `DATA_CLOCK_SIGNAL`, `busy`, `frame_done` = 0. State = IDLE.
- Clock periods:
  - Data clock period = 2·`DATA_DIV` cycles.
  - First data clock rise is at cycle `DATA_DIV` after reset release.
  - Board clock period = 2·`BOARD_DIV` cycles.
- Handshake:
  - `load` is accepted in cycle t.
  - `busy` goes high at t+1.
  - The first bit appears at the first tick after t+1.
  - Latency from `load` to the first bit is between 1 and 2·`DATA_DIV` cycles.
- Frame length: `4*WORDS + GAP_BITS` ticks.
- `frame_done` is asserted in the cycle after the last gap tick. With `CONTINUOUS`=0, `busy` falls in that same cycle.
- `load` in the same cycle as `frame_done` (`CONTINUOUS`=0) is ignored; it is accepted from the following cycle.
- A tick coinciding with the cycle `load` is accepted does not shift a bit.

## Test plan
- **Basic frame.** Config: `WORDS`=2, `DATA_DIV`=2, `BOARD_DIV`=1, `GAP_BITS`=2, `LSD_FIRST`=1, `CONTINUOUS`=0, `VALUE_BCD`=8'h59, `load` pulse.
  - `VALUE_SIGNAL` at successive ticks = 1,0,0,1,0,1,0,1 with `ENABLE_SIGNAL`=1.
  - Then 2 ticks with `ENABLE_SIGNAL`=0.
  - Then `frame_done` pulses once and `busy` drops.
- **Digit order.** Same as basic frame with `LSD_FIRST`=0: serial bits = 0,1,0,1,1,0,0,1.
- **Dividers.** `BOARD_DIV`=3, `DATA_DIV`=5, no load.
  - Board clock toggles every 3 cycles; data clock toggles every 5 cycles, first rise at cycle 5.
  - `busy` stays 0.
- **Continuous and snapshot.** `CONTINUOUS`=1, `VALUE_BCD`=8'h12, changed to 8'h34 mid-frame.
  - Frame 1 carries 0010,0001.
  - Frame 2 starts immediately after the gap and carries 0100,0011.
- **Ignored load.** `load` pulsed while busy and again in the `frame_done` cycle: no extra frame starts.
- **Mid-frame reset.** `RST` low for 1 cycle during bit 3: all outputs are 0 at once. After release with `CONTINUOUS`=0 the block stays IDLE until the next `load`.
